// File: rtl/rps_match_scorer.sv
// rps_match_scorer: keeps per-player round wins and a counted-round tally
// for one stone-paper-scissors match. It closes the match when a player
// reaches WIN_TARGET wins or MAX_ROUNDS counted rounds have been played.
module rps_match_scorer #(
   parameter int WIN_TARGET = 3,
   parameter int MAX_ROUNDS = 9,
   parameter int CNT_W      = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             result_valid,
   input  logic [1:0]       result,
   input  logic             new_match,
   output logic [CNT_W-1:0] score_p1,
   output logic [CNT_W-1:0] score_p2,
   output logic [CNT_W-1:0] round_cnt,
   output logic [1:0]       last_result,
   output logic             round_ack,
   output logic             invalid_seen,
   output logic             match_done,
   output logic [1:0]       match_winner
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] RES_TIE     = 2'b00;
   localparam logic [1:0] RES_P1      = 2'b01;
   localparam logic [1:0] RES_P2      = 2'b10;
   localparam logic [1:0] RES_INVALID = 2'b11;

   localparam logic [CNT_W-1:0] TARGET = CNT_W'(WIN_TARGET);
   localparam logic [CNT_W-1:0] LIMIT  = CNT_W'(MAX_ROUNDS);
   localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

   state_t           state;
   logic [CNT_W-1:0] p1_next;
   logic [CNT_W-1:0] p2_next;
   logic [CNT_W-1:0] rounds_next;

   // Post-update counter values if the current result were accepted, so the
   // end-of-match decision sees the same numbers the registers will hold.
   always_comb begin
      p1_next     = score_p1;
      p2_next     = score_p2;
      rounds_next = round_cnt;
      case (result)
         RES_P1: begin
            p1_next     = score_p1 + ONE;
            rounds_next = round_cnt + ONE;
         end
         RES_P2: begin
            p2_next     = score_p2 + ONE;
            rounds_next = round_cnt + ONE;
         end
         RES_TIE: begin
            rounds_next = round_cnt + ONE;
         end
         default: begin
         end
      endcase
   end

   // Match controller: reset beats new_match, which beats an incoming result.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         score_p1     <= '0;
         score_p2     <= '0;
         round_cnt    <= '0;
         last_result  <= 2'b00;
         round_ack    <= 1'b0;
         invalid_seen <= 1'b0;
         match_done   <= 1'b0;
         match_winner <= 2'b00;
      end else begin
         round_ack <= 1'b0;
         if (new_match) begin
            state        <= PLAY;
            score_p1     <= '0;
            score_p2     <= '0;
            round_cnt    <= '0;
            last_result  <= 2'b00;
            invalid_seen <= 1'b0;
            match_done   <= 1'b0;
            match_winner <= 2'b00;
         end else if (state == PLAY && result_valid) begin
            score_p1    <= p1_next;
            score_p2    <= p2_next;
            round_cnt   <= rounds_next;
            last_result <= result;
            round_ack   <= 1'b1;
            if (result == RES_INVALID) begin
               invalid_seen <= 1'b1;
            end
            if (p1_next == TARGET) begin
               state        <= DONE;
               match_done   <= 1'b1;
               match_winner <= RES_P1;
            end else if (p2_next == TARGET) begin
               state        <= DONE;
               match_done   <= 1'b1;
               match_winner <= RES_P2;
            end else if (rounds_next == LIMIT) begin
               state      <= DONE;
               match_done <= 1'b1;
               if (p1_next > p2_next) begin
                  match_winner <= RES_P1;
               end else if (p2_next > p1_next) begin
                  match_winner <= RES_P2;
               end else begin
                  match_winner <= 2'b11;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_rps_match_scorer.sv
// Testbench for rps_match_scorer: directed scenarios plus a random run, all
// checked against a rule-level model of the match kept in plain integers.
module tb_rps_match_scorer;

   localparam int WT = 3;
   localparam int MR = 9;
   localparam int W  = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         result_valid;
   logic [1:0]   result;
   logic         new_match;
   logic [W-1:0] score_p1;
   logic [W-1:0] score_p2;
   logic [W-1:0] round_cnt;
   logic [1:0]   last_result;
   logic         round_ack;
   logic         invalid_seen;
   logic         match_done;
   logic [1:0]   match_winner;

   logic [18:0]  obs;

   int nCompared   = 0;
   int nMismatched = 0;

   // Reference model: 0 idle, 1 playing, 2 finished
   int m_mode, m_p1, m_p2, m_rc, m_last, m_ack, m_inv, m_win;

   rps_match_scorer #(.WIN_TARGET(WT), .MAX_ROUNDS(MR), .CNT_W(W)) dut (
      .clk(clk),
      .rst(rst),
      .result_valid(result_valid),
      .result(result),
      .new_match(new_match),
      .score_p1(score_p1),
      .score_p2(score_p2),
      .round_cnt(round_cnt),
      .last_result(last_result),
      .round_ack(round_ack),
      .invalid_seen(invalid_seen),
      .match_done(match_done),
      .match_winner(match_winner)
   );

   // Free-running clock
   always #5 clk = ~clk;

   assign obs = {score_p1, score_p2, round_cnt, last_result, round_ack,
                 invalid_seen, match_done, match_winner};

   // Apply one round of the match rules to the model
   function automatic void model_step(input logic rv, input logic [1:0] res,
                                      input logic nm, input logic r);
      m_ack = 0;
      if (r) begin
         m_mode = 0; m_p1 = 0; m_p2 = 0; m_rc = 0;
         m_last = 0; m_inv = 0; m_win = 0;
      end else if (nm) begin
         m_mode = 1; m_p1 = 0; m_p2 = 0; m_rc = 0;
         m_last = 0; m_inv = 0; m_win = 0;
      end else if (m_mode == 1 && rv) begin
         m_last = int'(res);
         m_ack  = 1;
         if (res == 2'b11) begin
            m_inv = 1;
         end else begin
            m_rc = m_rc + 1;
            if (res == 2'b01) m_p1 = m_p1 + 1;
            if (res == 2'b10) m_p2 = m_p2 + 1;
         end
         if (m_p1 == WT) begin
            m_mode = 2; m_win = 1;
         end else if (m_p2 == WT) begin
            m_mode = 2; m_win = 2;
         end else if (m_rc == MR) begin
            m_mode = 2;
            m_win  = (m_p1 > m_p2) ? 1 : ((m_p2 > m_p1) ? 2 : 3);
         end
      end
   endfunction

   // Model outputs packed in the same order as obs
   function automatic logic [18:0] expPack();
      return {W'(m_p1), W'(m_p2), W'(m_rc), 2'(m_last), 1'(m_ack),
              1'(m_inv), (m_mode == 2), 2'(m_win)};
   endfunction

   // Drive one clock cycle of inputs, update the model, sample after the edge
   task automatic applyStimulus(input logic rv, input logic [1:0] res,
                                input logic nm, input logic r);
      result_valid = rv;
      result       = res;
      new_match    = nm;
      rst          = r;
      @(posedge clk);
      model_step(rv, res, nm, r);
      #1;
   endtask

   task automatic test_reset();
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b1);
      nCompared++;
      if (obs !== 19'd0) begin
         nMismatched++;
         $display("[TB] FAIL reset: got %h expected %h", obs, 19'd0);
      end
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
   endtask

   task automatic test_idle_ignore();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
         nCompared++;
         if (obs !== expPack()) begin
            nMismatched++;
            $display("[TB] FAIL idle_ignore[%0d]: got %h expected %h", i, obs, expPack());
         end
      end
      nCompared++;
      if (obs !== 19'd0) begin
         nMismatched++;
         $display("[TB] FAIL idle_zero: got %h expected %h", obs, 19'd0);
      end
   endtask

   task automatic test_p1_win();
      int seq[4];
      int acks;
      seq  = '{1, 2, 1, 1};
      acks = 0;
      applyStimulus(1'b0, 2'b00, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 2'(seq[i]), 1'b0, 1'b0);
         acks += int'(round_ack);
         nCompared++;
         if (obs !== expPack()) begin
            nMismatched++;
            $display("[TB] FAIL p1_win[%0d]: got %h expected %h", i, obs, expPack());
         end
      end
      nCompared++;
      if ({score_p1, score_p2, round_cnt, match_done, match_winner} !==
          {4'd3, 4'd1, 4'd4, 1'b1, 2'b01} || acks != 4) begin
         nMismatched++;
         $display("[TB] FAIL p1_win_final: got p1=%0d p2=%0d rc=%0d done=%0b win=%b acks=%0d expected 3 1 4 1 01 4",
                  score_p1, score_p2, round_cnt, match_done, match_winner, acks);
      end
   endtask

   task automatic test_invalid_p2();
      int seq[5];
      seq = '{0, 3, 2, 2, 2};
      applyStimulus(1'b0, 2'b00, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 2'(seq[i]), 1'b0, 1'b0);
         nCompared++;
         if (obs !== expPack()) begin
            nMismatched++;
            $display("[TB] FAIL invalid_p2[%0d]: got %h expected %h", i, obs, expPack());
         end
         if (i == 1) begin
            nCompared++;
            if (invalid_seen !== 1'b1 || round_cnt !== 4'd1) begin
               nMismatched++;
               $display("[TB] FAIL invalid_flag: got inv=%0b rc=%0d expected 1 1", invalid_seen, round_cnt);
            end
         end
      end
      nCompared++;
      if ({score_p2, round_cnt, match_winner} !== {4'd3, 4'd4, 2'b10}) begin
         nMismatched++;
         $display("[TB] FAIL p2_win_final: got p2=%0d rc=%0d win=%b expected 3 4 10",
                  score_p2, round_cnt, match_winner);
      end
      applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
      nCompared++;
      if (obs !== expPack() || round_ack !== 1'b0 || score_p1 !== 4'd0) begin
         nMismatched++;
         $display("[TB] FAIL done_hold: got %h expected %h", obs, expPack());
      end
   endtask

   task automatic test_round_limit();
      int seqs[3][9];
      logic [1:0] expWin[3];
      seqs   = '{'{0, 0, 0, 0, 0, 0, 0, 0, 0},
                 '{1, 1, 2, 2, 0, 0, 0, 0, 0},
                 '{1, 1, 2, 0, 0, 0, 0, 0, 0}};
      expWin = '{2'b11, 2'b11, 2'b01};
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 2'b00, 1'b1, 1'b0);
         for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, 2'(seqs[k][i]), 1'b0, 1'b0);
            nCompared++;
            if (obs !== expPack()) begin
               nMismatched++;
               $display("[TB] FAIL limit%0d[%0d]: got %h expected %h", k, i, obs, expPack());
            end
         end
         nCompared++;
         if (match_done !== 1'b1 || match_winner !== expWin[k] || round_cnt !== 4'd9) begin
            nMismatched++;
            $display("[TB] FAIL limit%0d_final: got done=%0b win=%b rc=%0d expected 1 %b 9",
                     k, match_done, match_winner, round_cnt, expWin[k]);
         end
      end
   endtask

   task automatic test_new_match_priority();
      applyStimulus(1'b0, 2'b00, 1'b1, 1'b0);
      applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'b10, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'b01, 1'b1, 1'b0);
      nCompared++;
      if (obs !== expPack() || score_p1 !== 4'd0 || round_ack !== 1'b0) begin
         nMismatched++;
         $display("[TB] FAIL nm_priority: got %h expected %h", obs, expPack());
      end
      applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
      nCompared++;
      if (round_ack !== 1'b1 || score_p1 !== 4'd1) begin
         nMismatched++;
         $display("[TB] FAIL nm_then_play: got ack=%0b p1=%0d expected 1 1", round_ack, score_p1);
      end
   endtask

   task automatic test_rst_mid();
      applyStimulus(1'b0, 2'b00, 1'b1, 1'b0);
      applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
      applyStimulus(1'b1, 2'b01, 1'b1, 1'b1);
      nCompared++;
      if (obs !== 19'd0) begin
         nMismatched++;
         $display("[TB] FAIL rst_mid: got %h expected %h", obs, 19'd0);
      end
      applyStimulus(1'b1, 2'b01, 1'b0, 1'b0);
      nCompared++;
      if (obs !== 19'd0) begin
         nMismatched++;
         $display("[TB] FAIL rst_then_idle: got %h expected %h", obs, 19'd0);
      end
   endtask

   task automatic test_back_to_back_random();
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(0, 99) < 75,
                       2'($urandom_range(0, 3)),
                       $urandom_range(0, 99) < 6,
                       $urandom_range(0, 99) < 2);
         nCompared++;
         if (obs !== expPack()) begin
            nMismatched++;
            $display("[TB] FAIL random[%0d]: got %h expected %h", i, obs, expPack());
         end
      end
   endtask

   initial begin
      rst          = 1'b0;
      result_valid = 1'b0;
      result       = 2'b00;
      new_match    = 1'b0;
      model_step(1'b0, 2'b00, 1'b0, 1'b1);
      test_reset();
      test_idle_ignore();
      test_p1_win();
      test_invalid_p2();
      test_round_limit();
      test_new_match_priority();
      test_rst_mid();
      test_back_to_back_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
